// File: rtl/cifra_simon_ctrl.sv
// Simon128/128 encryption sequencer: accepts one plaintext/key pair, runs 68 rounds at one per clock,
// expands round keys on the fly and holds the ciphertext until consumed. Optional macro: SIMON_ABORT_EN.
module cifra_simon_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] key_i,
  input  logic [127:0] pt_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] ct_o,
  output logic         busy_o
`ifdef SIMON_ABORT_EN
  ,
  input  logic         abort_i
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [63:0] C_CONST  = 64'hFFFF_FFFF_FFFF_FFFC;
  // z2 stored MSB-first: sequence bit i lives at Z2[61-i].
  localparam logic [61:0] Z2       = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [6:0]  LAST_RND = 7'd67;
  localparam logic [6:0]  Z_LEN    = 7'd62;

  state_t      state, state_next;
  logic [63:0] x, y, ka, kb;
  logic [6:0]  rnd;
  logic        load, step, clear;
  logic        abort;

`ifdef SIMON_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // Round function and key-schedule next values.
  logic [63:0] f_x;
  logic [63:0] x_next;
  logic [63:0] kb_r3, kb_r4;
  logic [63:0] kb_next;
  logic [5:0]  z_idx;
  logic        z_bit;

  assign f_x     = ({x[62:0], x[63]} & {x[55:0], x[63:56]}) ^ {x[61:0], x[63:62]};
  assign x_next  = y ^ f_x ^ ka;
  assign kb_r3   = {kb[2:0], kb[63:3]};
  assign kb_r4   = {kb_r3[0], kb_r3[63:1]};
  assign z_idx   = (rnd >= Z_LEN) ? 6'(rnd - Z_LEN) : rnd[5:0];
  assign z_bit   = Z2[6'd61 - z_idx];
  assign kb_next = C_CONST ^ {63'd0, z_bit} ^ ka ^ kb_r3 ^ kb_r4;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    clear      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid_i && !abort) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          clear      = 1'b1;
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (rnd == LAST_RND) state_next = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          clear      = 1'b1;
          state_next = IDLE;
        end else if (out_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath keeps its value after DONE so ct_o still reflects the last block while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      ka  <= '0;
      kb  <= '0;
      rnd <= '0;
    end else if (clear) begin
      x   <= '0;
      y   <= '0;
      ka  <= '0;
      kb  <= '0;
      rnd <= '0;
    end else if (load) begin
      x   <= pt_i[127:64];
      y   <= pt_i[63:0];
      ka  <= key_i[63:0];
      kb  <= key_i[127:64];
      rnd <= '0;
    end else if (step) begin
      x   <= x_next;
      y   <= x;
      ka  <= kb;
      kb  <= kb_next;
      rnd <= rnd + 7'd1;
    end
  end

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign ct_o        = {x, y};

endmodule

// File: tb/tb_cifra_simon_ctrl.sv
// Scoreboard bench for cifra_simon_ctrl: directed Simon128/128 vectors plus random blocks checked
// against a behavioural key-schedule/round model; abort tests run only when SIMON_ABORT_EN is defined.
module tb_cifra_simon_ctrl;

  localparam logic [127:0] KEY_STD = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] PT_STD  = 128'h63736564_20737265_6c6c6576_61727420;
  localparam logic [127:0] CT_STD  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;

  logic         clk;
  logic         rst_n;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] key_i;
  logic [127:0] pt_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] ct_o;
  logic         busy_o;
  logic         abort_i;

  int n_checks;
  int n_fail;
  int cyc;

  logic [127:0] exp_q[$];
  int           acc_q[$];
  int           acc_log[$];
  logic         prev_valid;
  logic [127:0] held_ct;

  cifra_simon_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .key_i      (key_i),
    .pt_i       (pt_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .ct_o       (ct_o),
    .busy_o     (busy_o)
`ifdef SIMON_ABORT_EN
    ,
    .abort_i    (abort_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out or unexpected event (t=%0t)", name, $time);
  endtask

  // Reference model: full key schedule first, then 68 Feistel rounds.
  function automatic logic [63:0] rol(input logic [63:0] v, input int s);
    return (v << s) | (v >> (64 - s));
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int s);
    return rol(v, 64 - s);
  endfunction

  function automatic logic [127:0] simon_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [63:0] k[0:67];
    logic [63:0] x, y, t, tmp;
    string zs;
    zs   = "10101111011100000011010010011000101000010001111110010110110011";
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int i = 0; i < 66; i++) begin
      tmp    = ror(k[i+1], 3);
      tmp    = tmp ^ ror(tmp, 1);
      k[i+2] = ~k[i] ^ tmp ^ 64'd3 ^ ((zs[i % 62] == "1") ? 64'd1 : 64'd0);
    end
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 68; i++) begin
      t = x;
      x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Monitor: samples on the falling edge, predicts accepts and scores every handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (in_valid_i && in_ready_o && !abort_i) begin
        exp_q.push_back(simon_ref(key_i, pt_i));
        acc_q.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
      end
      if (out_valid_o && !prev_valid) begin
        if (acc_q.size() == 0) fail_now("unexpected_out_valid");
        else check("latency", 128'(cyc - acc_q.pop_front()), 128'd68);
        held_ct = ct_o;
      end else if (out_valid_o) begin
        check("stall_ct_stable", ct_o, held_ct);
      end
      if (busy_o) check("in_ready_low_when_busy", {127'd0, in_ready_o}, 128'd0);
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) fail_now("output_without_expectation");
        else check("ciphertext", ct_o, exp_q.pop_front());
      end
      prev_valid = out_valid_o;
    end
  end

  task automatic send(input logic [127:0] k, input logic [127:0] p);
    int n;
    key_i      = k;
    pt_i       = p;
    in_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_now("send_wait_ready");
    @(posedge clk);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("wait_out_valid");
  endtask

  task automatic wait_drain(input bit rand_ready);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1 out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end while ((busy_o || exp_q.size() != 0) && n < 600);
    if (n >= 600) fail_now("wait_drain");
    out_ready_i = 1'b1;
  endtask

  initial begin
    int n0, n;
    n_checks    = 0;
    n_fail      = 0;
    prev_valid  = 1'b0;
    held_ct     = '0;
    rst_n       = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    abort_i     = 1'b0;
    key_i       = '0;
    pt_i        = '0;

    #22;
    check("reset_in_ready", {127'd0, in_ready_o}, 128'd1);
    check("reset_busy", {127'd0, busy_o}, 128'd0);
    check("reset_out_valid", {127'd0, out_valid_o}, 128'd0);
    check("reset_ct", ct_o, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Standard vector.
    send(KEY_STD, PT_STD);
    wait_valid();
    check("std_vector", ct_o, CT_STD);
    wait_drain(1'b0);

    // Back-to-back with in_valid held high.
    n0 = acc_log.size();
    key_i = KEY_STD;
    pt_i = PT_STD;
    in_valid_i = 1'b1;
    out_ready_i = 1'b1;
    n = 0;
    while (acc_log.size() < n0 + 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid_i = 1'b0;
    if (acc_log.size() < n0 + 2) fail_now("back_to_back_accepts");
    else check("back_to_back_spacing", 128'(acc_log[n0+1] - acc_log[n0]), 128'd70);
    wait_drain(1'b0);

    // Backpressure for 20 cycles.
    out_ready_i = 1'b0;
    send(KEY_STD, PT_STD);
    wait_valid();
    repeat (20) @(posedge clk);
    #1;
    check("bp_still_valid", {127'd0, out_valid_o}, 128'd1);
    check("bp_ct", ct_o, CT_STD);
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("bp_consumed_valid", {127'd0, out_valid_o}, 128'd0);
    check("bp_consumed_ready", {127'd0, in_ready_o}, 128'd1);

    // Inputs change after accept.
    send(KEY_STD, PT_STD);
    repeat (5) @(posedge clk);
    #1;
    key_i = '1;
    pt_i  = '1;
    wait_valid();
    check("input_change_ct", ct_o, CT_STD);
    wait_drain(1'b0);

    // Reset in the middle of RUN at rnd=30.
    send(KEY_STD, PT_STD);
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("midreset_out_valid", {127'd0, out_valid_o}, 128'd0);
    check("midreset_in_ready", {127'd0, in_ready_o}, 128'd1);
    check("midreset_ct", ct_o, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(KEY_STD, PT_STD);
    wait_valid();
    check("after_reset_ct", ct_o, CT_STD);
    wait_drain(1'b0);

    // Random blocks with random consumer stalls.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      wait_drain(1'b1);
    end

`ifdef SIMON_ABORT_EN
    send(KEY_STD, PT_STD);
    repeat (10) @(posedge clk);
    #1 abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    exp_q.delete();
    acc_q.delete();
    check("abort_busy", {127'd0, busy_o}, 128'd0);
    check("abort_ct_cleared", ct_o, 128'd0);
    repeat (80) @(posedge clk);
    #1;
    check("abort_no_valid", {127'd0, out_valid_o}, 128'd0);
    abort_i = 1'b1;
    in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    abort_i = 1'b0;
    check("abort_blocks_accept", {127'd0, busy_o}, 128'd0);
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cifra_simon_ctrl.md
# cifra_simon_ctrl

Sequencer for a complete Simon128/128 encryption. It accepts one 128-bit plaintext and one 128-bit key through a valid/ready handshake. It then runs the 68 rounds one per clock, expanding the 64-bit round keys on the fly, and presents the 128-bit ciphertext through a valid/ready handshake. It sits between the bus-side request logic and the result buffer, and owns all round counting and z2 constant sequencing.

## Interface
- Parameters: none. Simon128/128 is fixed: 64-bit words, m=2, T=68 rounds, z2 sequence.
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid_i`  in  1  request valid.
- `in_ready_o`  out  1  block can accept a request.
- `key_i`  in  128  key. [63:0] is k0, [127:64] is k1.
- `pt_i`  in  128  plaintext. [127:64] is x, [63:0] is y.
- `out_valid_o`  out  1  ciphertext valid.
- `out_ready_i`  in  1  consumer accepts ciphertext.
- `ct_o`  out  128  ciphertext {x,y}.
- `busy_o`  out  1  state is not IDLE.
- `abort_i`  in  1  only when SIMON_ABORT_EN is defined.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - in_ready_o=1.
  - When in_valid_i=1 at the edge (accept): load x, y from pt_i; load ka=key_i[63:0], kb=key_i[127:64]; set rnd=0 (7-bit); go to RUN.
- **RUN**, one round per cycle:
  - x <= y ^ f(x) ^ ka, where f(x) = (ROL1(x) & ROL8(x)) ^ ROL2(x).
  - y <= x.
  - ka <= kb.
  - kb <= c ^ z[rnd mod 62] ^ ka ^ ROR3(kb) ^ ROR1(ROR3(kb)).
  - c = 64'hFFFF_FFFF_FFFF_FFFC.
  - z[i] is the i-th bit, counted left to right, of 10101111011100000011010010011000101000010001111110010110110011.
  - rnd increments each cycle. When rnd=67 is processed, go to DONE.
  - Key words computed beyond k67 are unused and harmless.
- **DONE**
  - out_valid_o=1 and ct_o={x,y}, held stable.
  - When out_ready_i=1 at the edge, go to IDLE.
- Data ownership:
  - key_i and pt_i are sampled only at accept. Later changes have no effect.
  - ct_o is meaningful only while out_valid_o=1.
  - Outside DONE, ct_o shows the internal registers.
- The z index wraps: rnd 62..67 uses z[0..5].
- All arithmetic is 64-bit XOR/AND/rotate. There is no carry.

## Timing
- Reset values:
  - State IDLE, so in_ready_o=1 and busy_o=0.
  - out_valid_o=0.
  - ct_o=0; x, y, ka, kb, rnd all 0.
- Reset mid-operation: on rst_n low, go immediately to IDLE, clear all registers, drop any in-flight block with no output.
- Latency: out_valid_o rises exactly 68 clocks after the accept edge.
- Throughput:
  - No overlap. in_ready_o=0 in RUN and DONE.
  - Minimum 70 cycles per block: 1 accept, 68 RUN, 1 DONE with out_ready_i=1.
- out_valid_o stays high through any number of stall cycles while out_ready_i=0. ct_o is unchanged during the stall.
- in_valid_i=1 while in RUN or DONE is ignored and not queued. The requester must hold it until in_ready_o=1.

## Configuration
- Macro: SIMON_ABORT_EN.
- When defined:
  - Port abort_i exists.
  - abort_i=1 at an edge in RUN or DONE moves the FSM to IDLE and clears x, y, ka, kb, rnd.
  - out_valid_o drops in the next cycle and no output is produced.
  - In IDLE, abort_i=1 with in_valid_i=1 blocks the accept; abort has priority.
- When undefined: abort_i is absent. Every accepted block completes and waits in DONE until consumed.

## Test plan
- Standard vector: key_i=0f0e0d0c0b0a0908_0706050403020100, pt_i=63736564_20737265_6c6c6576_61727420 -> ct_o=49681b1e1e54fe3f_65aa832af84e0bbc, with out_valid_o rising 68 cycles after accept.
- Back-to-back: in_valid_i held high with out_ready_i=1 for two identical requests -> second accept exactly 70 cycles after first, both outputs match the vector.
- Backpressure: out_ready_i=0 for 20 cycles after out_valid_o -> ct_o stable, in_ready_o=0 throughout; consumption happens on the first out_ready_i=1 edge, then IDLE.
- Input change after accept: alter key_i and pt_i to all-ones at cycle 5 of RUN -> ciphertext still equals the standard vector.
- Reset at rnd=30 -> out_valid_o=0, in_ready_o=1, ct_o=0 immediately; a fresh request afterwards yields the correct vector.
- (SIMON_ABORT_EN) abort_i pulse at rnd=10 -> IDLE next cycle, no out_valid_o. abort_i with in_valid_i in IDLE -> busy_o stays 0.
